// File: rtl/sequence_generator_if.sv
// rtl/sequence_generator_if.sv - request/status bundle between a sequence_generator and its user
interface sequence_generator_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int RPT_W = 4
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [RPT_W-1:0] repeat_cnt;
  logic             x;
  logic             x_valid;
  logic             last;
  logic             done;

  // requester side: issues start and the transmission parameters
  modport master (
    output start, pattern, len, repeat_cnt,
    input  ready, x, x_valid, last, done
  );

  // generator side
  modport slave (
    input  start, pattern, len, repeat_cnt,
    output ready, x, x_valid, last, done
  );
endinterface

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial pattern generator, LSB first, optional per-pass parity bit (SEQGEN_PARITY_EN)
module sequence_generator #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int RPT_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  sequence_generator_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = RPT_W + 1;

`ifdef SEQGEN_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t           state, state_d;
  logic [LEN_W-1:0] idx, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PW-1:0]    pass_left, pass_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             pass_end;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] idx_inc;
  logic [LEN_W-1:0] len_m1;
  logic             at_end;
  logic             final_pass;

  // out-of-range lengths (0 or above WIDTH) fall back to a full-width pass
  assign eff_len    = (bus.len == '0 || bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
  assign idx_inc    = idx + LEN_W'(1);
  assign len_m1     = len_q - LEN_W'(1);
  assign at_end     = (idx == len_m1);
  assign final_pass = (pass_left == PW'(1));

`ifdef SEQGEN_PARITY_EN
  logic par_bit;

  // even parity over the active len_q bits of the captured pattern
  always_comb begin
    par_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(len_q)) par_bit = par_bit ^ pattern_q[i];
    end
  end
`endif

  // next state plus the values the output registers will present next cycle
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    pass_d    = pass_left;
    pattern_d = pattern_q;
    len_d     = len_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    last_d    = 1'b0;
    done_d    = 1'b0;
    pass_end  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pattern_d = bus.pattern;
          len_d     = eff_len;
          pass_d    = PW'(bus.repeat_cnt) + PW'(1);
          idx_d     = '0;
          state_d   = SEND;
          x_d       = bus.pattern[0];
          x_valid_d = 1'b1;
`ifndef SEQGEN_PARITY_EN
          last_d    = (eff_len == LEN_W'(1)) && (bus.repeat_cnt == '0);
`endif
        end
      end
      SEND: begin
        if (!at_end) begin
          idx_d     = idx_inc;
          x_d       = pattern_q[idx_inc[IW-1:0]];
          x_valid_d = 1'b1;
`ifndef SEQGEN_PARITY_EN
          last_d    = final_pass && (idx_inc == len_m1);
`endif
        end else begin
`ifdef SEQGEN_PARITY_EN
          state_d   = PAR;
          x_d       = par_bit;
          x_valid_d = 1'b1;
          last_d    = final_pass;
`else
          pass_end  = 1'b1;
`endif
        end
      end
`ifdef SEQGEN_PARITY_EN
      PAR: pass_end = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    // end of a pass: either wrap straight into bit 0 of the next pass or finish
    if (pass_end) begin
      if (final_pass) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d   = SEND;
        idx_d     = '0;
        pass_d    = pass_left - PW'(1);
        x_d       = pattern_q[0];
        x_valid_d = 1'b1;
`ifndef SEQGEN_PARITY_EN
        last_d    = (len_q == LEN_W'(1)) && (pass_left == PW'(2));
`endif
      end
    end
  end

  // state, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      pass_left <= '0;
      pattern_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      len_q     <= len_d;
      pass_left <= pass_d;
      pattern_q <= pattern_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready   = (state == IDLE);
  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.last    = last_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - randomized and directed checks of sequence_generator against a bit-queue model
module tb_sequence_generator;
  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int RPT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sequence_generator_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .RPT_W(RPT_W)) bus ();

  sequence_generator #(.WIDTH(WIDTH), .LEN_W(LEN_W), .RPT_W(RPT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a transmission is simply the list of bits it must put on the line
  bit   bitq[$];
  logic e_x = 1'b0, e_xv = 1'b0, e_last = 1'b0, e_done = 1'b0;
  logic armed = 1'b0;

  task automatic push_txn(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] ln,
                          input logic [RPT_W-1:0] rp);
    int  l;
    bit  par;
    l = (ln == 0 || int'(ln) > WIDTH) ? WIDTH : int'(ln);
    par = 1'b0;
    for (int i = 0; i < l; i++) par = par ^ pat[i];
    for (int p = 0; p <= int'(rp); p++) begin
      for (int i = 0; i < l; i++) bitq.push_back(pat[i]);
`ifdef SEQGEN_PARITY_EN
      bitq.push_back(par);
`endif
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      bitq.delete();
      e_x    <= 1'b0;
      e_xv   <= 1'b0;
      e_last <= 1'b0;
      e_done <= 1'b0;
      armed  <= 1'b1;
    end else if (armed) begin
      if (bus.start && !e_xv) push_txn(bus.pattern, bus.len, bus.repeat_cnt);
      if (bitq.size() != 0) begin
        e_last <= (bitq.size() == 1);
        e_x    <= bitq.pop_front();
        e_xv   <= 1'b1;
        e_done <= 1'b0;
      end else begin
        e_done <= e_xv;
        e_xv   <= 1'b0;
        e_x    <= 1'b0;
        e_last <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("x", 32'(bus.x), 32'(e_x));
      chk("x_valid", 32'(bus.x_valid), 32'(e_xv));
      chk("last", 32'(bus.last), 32'(e_last));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("ready", 32'(bus.ready), 32'(!e_xv));
    end
  end

  // issue one request from the current negedge and record the stream until done
  task automatic run_txn(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] ln,
                         input logic [RPT_W-1:0] rp, input bit poke,
                         output logic [31:0] bits, output int nbits,
                         output int last_pos, output int done_pos);
    bits = '0; nbits = 0; last_pos = 0; done_pos = 0;
    bus.start = 1'b1; bus.pattern = pat; bus.len = ln; bus.repeat_cnt = rp;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pattern = 16'($urandom); bus.len = 5'($urandom); bus.repeat_cnt = 4'($urandom);
    for (int c = 1; c <= 400; c++) begin
      if (bus.x_valid) begin
        if (nbits < 32) bits[nbits] = bus.x;
        nbits++;
      end
      if (bus.last) last_pos = c;
      if (bus.done) begin
        done_pos = c;
        break;
      end
      if (poke && c == 2) bus.start = 1'b1;
      if (poke && c == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    if (done_pos == 0) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] pat,
                          input logic [LEN_W-1:0] ln, input logic [RPT_W-1:0] rp, input bit poke,
                          input logic [31:0] exp_bits, input int exp_n, input int exp_last,
                          input int exp_done);
    logic [31:0] bits;
    int n, lp, dp;
    run_txn(pat, ln, rp, poke, bits, n, lp, dp);
    chk({name, "_bits"}, bits, exp_bits);
    chk({name, "_nbits"}, 32'(n), 32'(exp_n));
    chk({name, "_last_pos"}, 32'(lp), 32'(exp_last));
    chk({name, "_done_pos"}, 32'(dp), 32'(exp_done));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b1;
    bus.pattern = 16'h0015;
    bus.len = 5'd6;
    bus.repeat_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.ready), 32'd1);

`ifdef SEQGEN_PARITY_EN
    directed("p15_l6",   16'h0015, 5'd6, 4'd0, 1'b1, 32'h55,    7,  7,  8);
    directed("p01_r2",   16'h0001, 5'd2, 4'd2, 1'b0, 32'h16D,   9,  9, 10);
    directed("a5c3_l0",  16'hA5C3, 5'd0, 4'd0, 1'b0, 32'h0A5C3, 17, 17, 18);
    directed("one_l1",   16'h0001, 5'd1, 4'd0, 1'b0, 32'h3,     2,  2,  3);
    directed("p15_r1",   16'h0015, 5'd6, 4'd1, 1'b0, 32'h2AD5,  14, 14, 15);
`else
    directed("p15_l6",   16'h0015, 5'd6, 4'd0, 1'b1, 32'h15,    6,  6,  7);
    directed("p01_r2",   16'h0001, 5'd2, 4'd2, 1'b0, 32'h15,    6,  6,  7);
    directed("a5c3_l0",  16'hA5C3, 5'd0, 4'd0, 1'b0, 32'hA5C3,  16, 16, 17);
    directed("one_l1",   16'h0001, 5'd1, 4'd0, 1'b0, 32'h1,     1,  1,  2);
    directed("p15_r1",   16'h0015, 5'd6, 4'd1, 1'b0, 32'h555,   12, 12, 13);
`endif

    // abort in the cycle that shows bit 3
    bus.start = 1'b1; bus.pattern = 16'h0015; bus.len = 5'd6; bus.repeat_cnt = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bit3_valid", 32'(bus.x_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_x_valid", 32'(bus.x_valid), 32'd0);
    chk("abort_x", 32'(bus.x), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);

    for (int c = 0; c < 4000; c++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.pattern = 16'($urandom);
      bus.len = 5'($urandom);
      bus.repeat_cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
